// File: rtl/step_selector_sync.sv
// -----------------------------------------------------------------------------
// step_selector_sync
//
// Turns a bank of raw mechanical switches into a committed "step count" for a
// downstream step generator. Each switch is synchronised, the whole vector is
// debounced as one word, the winning switch is priority-encoded into a step
// count, and that count is only committed while the step generator is not busy.
//
// Ports
//   clk            in   system clock, all logic on the rising edge
//   rst_n          in   synchronous active-low reset
//   sw             in   [N_SW]   raw asynchronous switch levels
//   busy           in   downstream generator mid-sequence; commits are held off
//   steps          out  [STEP_W] committed step count, 0..N_SW
//   steps_valid    out  committed step count is non-zero
//   steps_changed  out  one-cycle pulse on the edge steps takes a new value
//   pending        out  a debounced selection differs from steps, held by busy
//   multi_sel      out  more than one debounced switch on at the last commit
//
// Parameters
//   N_SW             number of switches, 1..15
//   STEP_W           output width, at least clog2(N_SW+1)
//   DEBOUNCE_CYCLES  stable cycles required before a new vector is accepted
//   PRIORITY_HIGH    1: highest set switch wins, 0: lowest set switch wins
// -----------------------------------------------------------------------------
module step_selector_sync #(
   parameter int N_SW            = 10,
   parameter int STEP_W          = 4,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int PRIORITY_HIGH   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_SW-1:0]   sw,
   input  logic              busy,
   output logic [STEP_W-1:0] steps,
   output logic              steps_valid,
   output logic              steps_changed,
   output logic              pending,
   output logic              multi_sel
);

   // Counter only has to reach DEBOUNCE_CYCLES-1; keep at least one bit so a
   // debounce of a single cycle still elaborates.
   localparam int               CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {
      IDLE,
      HOLD
   } state_t;

   // --------------------------------------------------------------------------
   // Two-flop synchroniser, one chain per switch bit.
   // --------------------------------------------------------------------------
   logic [N_SW-1:0] s1;
   logic [N_SW-1:0] s2;

   // NOTE: every clocked register below is assigned with <= so all flops see
   // the pre-edge values of their neighbours; a blocking = here would collapse
   // the two synchroniser stages into one.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= sw;
         s2 <= s1;
      end
   end

   // --------------------------------------------------------------------------
   // Vector-wide debounce. cand tracks the most recent synchronised vector; any
   // difference restarts the count, so only a vector that has been steady for
   // DEBOUNCE_CYCLES edges is copied into deb. Once saturated, deb is reloaded
   // with the same value every edge, which changes nothing.
   // --------------------------------------------------------------------------
   logic [N_SW-1:0]  cand;
   logic [N_SW-1:0]  deb;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cand <= '0;
         deb  <= '0;
         cnt  <= '0;
      end else if (s2 != cand) begin
         cand <= s2;
         cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
         cnt <= cnt + CNT_W'(1);
      end else begin
         deb <= cand;
      end
   end

   // --------------------------------------------------------------------------
   // Priority encoder: index+1 of the winning switch, 0 when nothing is on.
   // The loop walks towards the winning end so the last hit is the winner.
   // --------------------------------------------------------------------------
   function automatic logic [STEP_W-1:0] encode(input logic [N_SW-1:0] v);
      logic [STEP_W-1:0] r;
      // NOTE: r gets a value before any conditional write; without that first
      // assignment the combinational result would need memory and infer a latch.
      r = '0;
      for (int i = 0; i < N_SW; i++) begin
         if (PRIORITY_HIGH != 0) begin
            if (v[i]) r = STEP_W'(i + 1);
         end else begin
            if (v[N_SW-1-i]) r = STEP_W'(N_SW - i);
         end
      end
      return r;
   endfunction

   logic [STEP_W-1:0] enc;
   logic              deb_multi;

   always_comb begin
      enc       = encode(deb);
      // Clearing the lowest set bit leaves something only if two or more were set.
      deb_multi = (deb & (deb - N_SW'(1))) != '0;
   end

   // --------------------------------------------------------------------------
   // Commit FSM. Whenever busy is low the current encoder value is committed,
   // which also refreshes steps_valid and multi_sel from the same deb. While
   // busy is high steps is frozen; HOLD (and pending) marks that the frozen
   // value is stale. HOLD always commits the encoder value present at release,
   // not the one that caused the hold, and falls back to IDLE silently if the
   // selection returns to the committed value first.
   // --------------------------------------------------------------------------
   state_t state;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         steps         <= '0;
         steps_valid   <= 1'b0;
         steps_changed <= 1'b0;
         pending       <= 1'b0;
         multi_sel     <= 1'b0;
      end else begin
         steps_changed <= 1'b0;
         if (!busy) begin
            steps         <= enc;
            steps_valid   <= deb != '0;
            multi_sel     <= deb_multi;
            steps_changed <= enc != steps;
            pending       <= 1'b0;
            state         <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (enc != steps) begin
                     state   <= HOLD;
                     pending <= 1'b1;
                  end
               end
               HOLD: begin
                  if (enc == steps) begin
                     state   <= IDLE;
                     pending <= 1'b0;
                  end
               end
               default: begin
                  state   <= IDLE;
                  pending <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_step_selector_sync.sv
// -----------------------------------------------------------------------------
// tb_step_selector_sync
//
// Two instances share all inputs: u_hi (PRIORITY_HIGH=1) and u_lo
// (PRIORITY_HIGH=0), both with N_SW=10 and DEBOUNCE_CYCLES=4. Inputs change
// just after the falling edge, outputs are compared on the falling edge.
// Directed sequences use hand-computed constants; the random phase uses a
// reference model built on a history window of sampled switch vectors.
// -----------------------------------------------------------------------------
module tb_step_selector_sync;

   localparam int N  = 10;
   localparam int D  = 4;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  sw;
   logic          busy;

   logic [SW-1:0] steps_hi, steps_lo;
   logic          valid_hi, valid_lo;
   logic          changed_hi, changed_lo;
   logic          pending_hi, pending_lo;
   logic          multi_hi, multi_lo;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   step_selector_sync #(
      .N_SW(N), .STEP_W(SW), .DEBOUNCE_CYCLES(D), .PRIORITY_HIGH(1)
   ) u_hi (
      .clk(clk), .rst_n(rst_n), .sw(sw), .busy(busy),
      .steps(steps_hi), .steps_valid(valid_hi), .steps_changed(changed_hi),
      .pending(pending_hi), .multi_sel(multi_hi)
   );

   step_selector_sync #(
      .N_SW(N), .STEP_W(SW), .DEBOUNCE_CYCLES(D), .PRIORITY_HIGH(0)
   ) u_lo (
      .clk(clk), .rst_n(rst_n), .sw(sw), .busy(busy),
      .steps(steps_lo), .steps_valid(valid_lo), .steps_changed(changed_lo),
      .pending(pending_lo), .multi_sel(multi_lo)
   );

   // --------------------------------------------------------------------------
   // Reference model. A new vector reaches deb on edge k only when the vectors
   // sampled on edges k-2-D .. k-2 are all identical (two synchroniser edges
   // plus D stable cycles). Reset leaves three zero samples and no older ones.
   // After that: with busy low the output follows the encoder and pulses on a
   // change; with busy high the output is frozen and pending shows staleness.
   // Index 0 models u_lo, index 1 models u_hi.
   // --------------------------------------------------------------------------
   logic [N-1:0] hist[$];
   logic [N-1:0] m_deb;
   int           m_steps[2];
   int           m_valid[2];
   int           m_changed[2];
   int           m_pending[2];
   int           m_multi[2];

   function automatic int enc_ref(input logic [N-1:0] v, input int hi);
      int r;
      r = 0;
      for (int i = 0; i < N; i++) begin
         if (v[i] && (hi != 0 || r == 0)) r = i + 1;
      end
      return r;
   endfunction

   always @(posedge clk) begin
      int  e;
      int  last;
      bit  same;
      if (!rst_n) begin
         hist.delete();
         for (int j = 0; j < 3; j++) hist.push_back('0);
         m_deb = '0;
         for (int p = 0; p < 2; p++) begin
            m_steps[p] = 0; m_valid[p] = 0; m_changed[p] = 0;
            m_pending[p] = 0; m_multi[p] = 0;
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            e = enc_ref(m_deb, p);
            if (!busy) begin
               m_changed[p] = (e != m_steps[p]) ? 1 : 0;
               m_steps[p]   = e;
               m_valid[p]   = (m_deb != '0) ? 1 : 0;
               m_multi[p]   = ($countones(m_deb) > 1) ? 1 : 0;
               m_pending[p] = 0;
            end else begin
               m_changed[p] = 0;
               m_pending[p] = (e != m_steps[p]) ? 1 : 0;
            end
         end
         hist.push_back(sw);
         if (hist.size() > 16) void'(hist.pop_front());
         if (hist.size() >= D + 3) begin
            last = hist.size() - 3;
            same = 1'b1;
            for (int j = last - D; j <= last; j++) begin
               if (hist[j] != hist[last]) same = 1'b0;
            end
            if (same) m_deb = hist[last];
         end
      end
   end

   // --------------------------------------------------------------------------
   // Checking helpers
   // --------------------------------------------------------------------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // p = 1 checks u_hi, p = 0 checks u_lo
   task automatic check_inst(input int p, input string tag, input int e_steps,
                             input int e_valid, input int e_changed,
                             input int e_pending, input int e_multi);
      logic [SW-1:0] a_steps;
      logic          a_valid, a_changed, a_pending, a_multi;
      if (p == 1) begin
         a_steps = steps_hi; a_valid = valid_hi; a_changed = changed_hi;
         a_pending = pending_hi; a_multi = multi_hi;
      end else begin
         a_steps = steps_lo; a_valid = valid_lo; a_changed = changed_lo;
         a_pending = pending_lo; a_multi = multi_lo;
      end
      check({tag, (p == 1) ? ".hi" : ".lo", ".steps"},   32'(a_steps),   e_steps);
      check({tag, (p == 1) ? ".hi" : ".lo", ".valid"},   32'(a_valid),   e_valid);
      check({tag, (p == 1) ? ".hi" : ".lo", ".changed"}, 32'(a_changed), e_changed);
      check({tag, (p == 1) ? ".hi" : ".lo", ".pending"}, 32'(a_pending), e_pending);
      check({tag, (p == 1) ? ".hi" : ".lo", ".multi"},   32'(a_multi),   e_multi);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Leave sw steady with busy low long enough to be debounced and committed.
   task automatic settle(input logic [N-1:0] v);
      sw   = v;
      busy = 1'b0;
      cyc(10);
   endtask

   typedef struct {
      logic [N-1:0] sw;
      int           hi;
      int           lo;
      int           multi;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int hold_left;

      vecs[0] = '{10'h001,  1, 1, 0};
      vecs[1] = '{10'h200, 10, 10, 0};
      vecs[2] = '{10'h210, 10, 5, 1};
      vecs[3] = '{10'h3FF, 10, 1, 1};
      vecs[4] = '{10'h00C,  4, 3, 1};
      vecs[5] = '{10'h080,  8, 8, 0};
      vecs[6] = '{10'h041,  7, 1, 1};
      vecs[7] = '{10'h000,  0, 0, 0};

      rst_n = 1'b0;
      sw    = 10'h3FF;
      busy  = 1'b0;

      // All switches on through reset: reset state, then full latency to E8.
      cyc(3);
      check_inst(1, "reset", 0, 0, 0, 0, 0);
      check_inst(0, "reset", 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      cyc(7);
      check_inst(1, "rel_e7", 0, 0, 0, 0, 0);
      cyc(1);
      check_inst(1, "rel_e8", 10, 1, 1, 0, 1);
      check_inst(0, "rel_e8", 1, 1, 1, 0, 1);
      cyc(1);
      check_inst(1, "rel_e9", 10, 1, 0, 0, 1);

      // Static priority table, both instances.
      for (int i = 0; i < 8; i++) begin
         settle(vecs[i].sw);
         check_inst(1, $sformatf("vec%0d", i), vecs[i].hi, (vecs[i].hi != 0) ? 1 : 0, 0, 0, vecs[i].multi);
         check_inst(0, $sformatf("vec%0d", i), vecs[i].lo, (vecs[i].lo != 0) ? 1 : 0, 0, 0, vecs[i].multi);
      end

      // Three-cycle glitch never reaches the output.
      settle('0);
      sw = 10'h001;
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         check_inst(1, "glitch", 0, 0, 0, 0, 0);
      end
      sw = '0;
      for (int i = 0; i < 12; i++) begin
         cyc(1);
         check_inst(1, "glitch", 0, 0, 0, 0, 0);
      end

      // Busy holds off the commit; release commits on the next edge.
      settle('0);
      busy = 1'b1;
      sw   = 10'h010;
      cyc(7);
      check_inst(1, "busy_e7", 0, 0, 0, 0, 0);
      cyc(1);
      check_inst(1, "busy_e8", 0, 0, 0, 1, 0);
      cyc(3);
      check_inst(1, "busy_hold", 0, 0, 0, 1, 0);
      busy = 1'b0;
      cyc(1);
      check_inst(1, "busy_rel", 5, 1, 1, 0, 0);
      cyc(1);
      check_inst(1, "busy_rel1", 5, 1, 0, 0, 0);

      // Selection changes while held: the latest value is committed.
      settle('0);
      busy = 1'b1;
      sw   = 10'h010;
      cyc(8);
      check_inst(1, "latest_hold", 0, 0, 0, 1, 0);
      sw = 10'h100;
      cyc(10);
      check_inst(1, "latest_hold2", 0, 0, 0, 1, 0);
      busy = 1'b0;
      cyc(1);
      check_inst(1, "latest_rel", 9, 1, 1, 0, 0);
      cyc(1);
      check_inst(1, "latest_rel1", 9, 1, 0, 0, 0);

      // Selection returns to the committed value while held: silent exit.
      settle('0);
      busy = 1'b1;
      sw   = 10'h010;
      cyc(8);
      check_inst(1, "revert_hold", 0, 0, 0, 1, 0);
      sw = '0;
      cyc(7);
      check_inst(1, "revert_f7", 0, 0, 0, 1, 0);
      cyc(1);
      check_inst(1, "revert_f8", 0, 0, 0, 0, 0);
      busy = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cyc(1);
         check_inst(1, "revert_rel", 0, 0, 0, 0, 0);
      end

      // Lowest-index priority, then all switches off.
      settle('0);
      sw = 10'h210;
      cyc(10);
      check_inst(0, "lo_210", 5, 1, 0, 0, 1);
      check_inst(1, "lo_210", 10, 1, 0, 0, 1);
      sw = '0;
      cyc(7);
      check_inst(0, "lo_off_e7", 5, 1, 0, 0, 1);
      cyc(1);
      check_inst(0, "lo_off_e8", 0, 0, 1, 0, 0);
      cyc(1);
      check_inst(0, "lo_off_e9", 0, 0, 0, 0, 0);

      // Reset two cycles into a debounce, then re-debounce from scratch.
      settle(10'h3FF);
      sw = 10'h004;
      cyc(2);
      rst_n = 1'b0;
      cyc(1);
      check_inst(1, "rst_mid", 0, 0, 0, 0, 0);
      check_inst(0, "rst_mid", 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      cyc(7);
      check_inst(1, "rst_mid_e7", 0, 0, 0, 0, 0);
      cyc(1);
      check_inst(1, "rst_mid_e8", 3, 1, 1, 0, 0);
      cyc(1);
      check_inst(1, "rst_mid_e9", 3, 1, 0, 0, 0);

      // Reset while held discards the pending selection.
      settle('0);
      busy = 1'b1;
      sw   = 10'h020;
      cyc(9);
      check_inst(1, "rst_hold_pre", 0, 0, 0, 1, 0);
      rst_n = 1'b0;
      sw    = '0;
      busy  = 1'b0;
      cyc(1);
      check_inst(1, "rst_hold", 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cyc(1);
         check_inst(1, "rst_hold_after", 0, 0, 0, 0, 0);
      end

      // Randomised phase against the reference model.
      hold_left = 0;
      for (int c = 0; c < 3000; c++) begin
         if (hold_left == 0) begin
            case ($urandom_range(0, 3))
               0:       sw = '0;
               1:       sw = N'(1 << $urandom_range(0, N - 1));
               default: sw = N'($urandom);
            endcase
            hold_left = $urandom_range(1, 10);
         end
         hold_left--;
         if ($urandom_range(0, 7) == 0) busy = ~busy;
         rst_n = ($urandom_range(0, 199) != 0);
         cyc(1);
         for (int p = 0; p < 2; p++) begin
            check_inst(p, "rand", m_steps[p], m_valid[p], m_changed[p], m_pending[p], m_multi[p]);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
